// File: rtl/mips_pkg.sv
// Shared MIPS definitions: opcodes, the canonical NOP word and IF/ID FSM encodings.
package mips_pkg;

  localparam logic [5:0]  OP_RTYPE  = 6'h00;
  localparam logic [5:0]  OP_BEQ    = 6'h04;
  localparam logic [5:0]  OP_BNE    = 6'h05;
  localparam logic [5:0]  OP_LW     = 6'h23;
  localparam logic [5:0]  OP_SW     = 6'h2B;

  // sll $0,$0,0
  localparam logic [31:0] NOP_INSTR = 32'h00000000;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_STALL   = 2'd1,
    ST_FLUSHED = 2'd2
  } estado_t;

endpackage

// File: rtl/if_id_hazard_if.sv
// IF/ID boundary bundle: IF-side inputs, ID/EX hazard inputs, control and decoded outputs.
interface if_id_hazard_if #(parameter int CNT_W = 16);

  logic [31:0]      pc_mais4_in;
  logic [31:0]      instrucao_in;
  logic             id_ex_memread;
  logic [4:0]       id_ex_rt;
  logic             branch_taken;
  logic             jump;
  logic             congela;
  logic             pcescreve;
  logic             bolha;
  logic             valido;
  logic [31:0]      pc_mais4_out;
  logic [31:0]      instrucao_out;
  logic [5:0]       opcode;
  logic [4:0]       rs;
  logic [4:0]       rt;
  logic [4:0]       rd;
  logic [4:0]       shamt;
  logic [5:0]       funct;
  logic [31:0]      imediato_ext;
  logic [1:0]       estado;
  logic [CNT_W-1:0] cont_stall;
  logic [CNT_W-1:0] cont_flush;

  modport master (
    output pc_mais4_in, instrucao_in, id_ex_memread, id_ex_rt, branch_taken, jump, congela,
    input  pcescreve, bolha, valido, pc_mais4_out, instrucao_out, opcode, rs, rt, rd,
           shamt, funct, imediato_ext, estado, cont_stall, cont_flush
  );

  modport slave (
    input  pc_mais4_in, instrucao_in, id_ex_memread, id_ex_rt, branch_taken, jump, congela,
    output pcescreve, bolha, valido, pc_mais4_out, instrucao_out, opcode, rs, rt, rd,
           shamt, funct, imediato_ext, estado, cont_stall, cont_flush
  );

endinterface

// File: rtl/if_id_hazard_hazard.sv
// Load-use hazard detection; purely combinational so forwarding logic can share it.
module hazard_unit
  import mips_pkg::*;
(
  input  logic       i_valido,
  input  logic       i_memread,
  input  logic [4:0] i_id_ex_rt,
  input  logic [5:0] i_opcode,
  input  logic [4:0] i_rs,
  input  logic [4:0] i_rt,
  output logic       o_usa_rt,
  output logic       o_haz
);

  // Only R-type, branches and stores read rt as a source operand.
  always_comb begin
    o_usa_rt = 1'b0;
    case (i_opcode)
      OP_RTYPE, OP_BEQ, OP_BNE, OP_SW: o_usa_rt = 1'b1;
      default:                         o_usa_rt = 1'b0;
    endcase
  end

  // Flag a dependency on a load that is still in EX.
  always_comb begin
    o_haz = 1'b0;
    if (i_valido && i_memread && (i_id_ex_rt != 5'd0)) begin
      o_haz = (i_id_ex_rt == i_rs) || (o_usa_rt && (i_id_ex_rt == i_rt));
    end else begin
      o_haz = 1'b0;
    end
  end

endmodule

// File: rtl/if_id_hazard.sv
// IF/ID pipeline register with field split, load-use stall, flush, freeze and event counters.
module if_id_hazard #(
  parameter logic [31:0] NOP_INSTR = mips_pkg::NOP_INSTR,
  parameter int          CNT_W     = 16
) (
  input  logic         clock,
  input  logic         reset_n,
  if_id_hazard_if.slave bus
);
  import mips_pkg::*;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [31:0]      r_pc_mais4;
  logic [31:0]      r_instrucao;
  logic             r_valido;
  estado_t          r_estado;
  logic [CNT_W-1:0] r_cont_stall;
  logic [CNT_W-1:0] r_cont_flush;

  logic             w_haz;
  logic             w_usa_rt;
  logic             w_flush;
  logic             w_sel_flush;
  logic             w_sel_load;
  logic             w_inc_stall;
  logic             w_inc_flush;
  logic             w_pcescreve;
  logic             w_bolha;
  estado_t          w_estado_nxt;

  assign w_flush = bus.branch_taken | bus.jump;

  hazard_unit u_hazard (
    .i_valido   (r_valido),
    .i_memread  (bus.id_ex_memread),
    .i_id_ex_rt (bus.id_ex_rt),
    .i_opcode   (r_instrucao[31:26]),
    .i_rs       (r_instrucao[25:21]),
    .i_rt       (r_instrucao[20:16]),
    .o_usa_rt   (w_usa_rt),
    .o_haz      (w_haz)
  );

  // Priority congela > flush > hazard > normal load; decides next state and PC/bubble controls.
  always_comb begin
    w_estado_nxt = r_estado;
    w_sel_flush  = 1'b0;
    w_sel_load   = 1'b0;
    w_inc_stall  = 1'b0;
    w_inc_flush  = 1'b0;
    w_pcescreve  = 1'b1;
    w_bolha      = 1'b0;
    if (bus.congela) begin
      w_pcescreve = 1'b0;
    end else if (w_flush) begin
      w_sel_flush  = 1'b1;
      w_inc_flush  = 1'b1;
      w_estado_nxt = ST_FLUSHED;
    end else if (w_haz) begin
      w_pcescreve  = 1'b0;
      w_bolha      = 1'b1;
      w_inc_stall  = 1'b1;
      w_estado_nxt = ST_STALL;
    end else begin
      w_sel_load   = 1'b1;
      w_estado_nxt = ST_RUN;
    end
  end

  // Pipeline register, FSM state and saturating event counters.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_pc_mais4   <= 32'h00000000;
      r_instrucao  <= NOP_INSTR;
      r_valido     <= 1'b0;
      r_estado     <= ST_RUN;
      r_cont_stall <= {CNT_W{1'b0}};
      r_cont_flush <= {CNT_W{1'b0}};
    end else begin
      if (w_sel_flush) begin
        r_pc_mais4  <= bus.pc_mais4_in;
        r_instrucao <= NOP_INSTR;
        r_valido    <= 1'b0;
      end else if (w_sel_load) begin
        r_pc_mais4  <= bus.pc_mais4_in;
        r_instrucao <= bus.instrucao_in;
        r_valido    <= 1'b1;
      end
      r_estado <= w_estado_nxt;
      if (w_inc_stall && (r_cont_stall != CNT_MAX)) begin
        r_cont_stall <= r_cont_stall + CNT_ONE;
      end
      if (w_inc_flush && (r_cont_flush != CNT_MAX)) begin
        r_cont_flush <= r_cont_flush + CNT_ONE;
      end
    end
  end

  assign bus.pcescreve     = w_pcescreve;
  assign bus.bolha         = w_bolha;
  assign bus.valido        = r_valido;
  assign bus.pc_mais4_out  = r_pc_mais4;
  assign bus.instrucao_out = r_instrucao;
  assign bus.opcode        = r_instrucao[31:26];
  assign bus.rs            = r_instrucao[25:21];
  assign bus.rt            = r_instrucao[20:16];
  assign bus.rd            = r_instrucao[15:11];
  assign bus.shamt         = r_instrucao[10:6];
  assign bus.funct         = r_instrucao[5:0];
  assign bus.imediato_ext  = {{16{r_instrucao[15]}}, r_instrucao[15:0]};
  assign bus.estado        = r_estado;
  assign bus.cont_stall    = r_cont_stall;
  assign bus.cont_flush    = r_cont_flush;

endmodule

// File: tb/tb_if_id_hazard.sv
// Scoreboard bench for if_id_hazard: expected register contents queued per edge, checked after it.
module tb_if_id_hazard;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        valido;
    logic [1:0]  estado;
  } exp_t;

  logic clk;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;
  exp_t sb[$];
  exp_t e;

  if_id_hazard_if #(.CNT_W(16)) bus ();

  if_id_hazard #(.NOP_INSTR(32'h00000000), .CNT_W(16)) dut (
    .clock   (clk),
    .reset_n (rst_n),
    .bus     (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.pc_mais4_in = 32'h0; bus.instrucao_in = 32'h0; bus.id_ex_memread = 1'b0;
    bus.id_ex_rt = 5'd0; bus.branch_taken = 1'b0; bus.jump = 1'b0; bus.congela = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    bus.instrucao_in = 32'h012A4020; bus.pc_mais4_in = 32'h00000004;
    tick();
    total++; if (bus.valido !== 1'b1) begin bad++; $display("FAIL rst_preload_valido got=%0h exp=1", bus.valido); end
    #3 rst_n = 1'b0;
    #1;
    total++; if (bus.instrucao_out !== 32'h0) begin bad++; $display("FAIL rst_instr got=%h exp=00000000", bus.instrucao_out); end
    total++; if (bus.pc_mais4_out !== 32'h0) begin bad++; $display("FAIL rst_pc got=%h exp=00000000", bus.pc_mais4_out); end
    total++; if (bus.valido !== 1'b0) begin bad++; $display("FAIL rst_valido got=%0h exp=0", bus.valido); end
    total++; if (bus.pcescreve !== 1'b1) begin bad++; $display("FAIL rst_pcescreve got=%0h exp=1", bus.pcescreve); end
    total++; if (bus.bolha !== 1'b0) begin bad++; $display("FAIL rst_bolha got=%0h exp=0", bus.bolha); end
    total++; if (bus.estado !== 2'd0) begin bad++; $display("FAIL rst_estado got=%0d exp=0", bus.estado); end
    total++; if (bus.cont_stall !== 16'd0 || bus.cont_flush !== 16'd0) begin
      bad++; $display("FAIL rst_counters got=%0d/%0d exp=0/0", bus.cont_stall, bus.cont_flush);
    end
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_normal();
    bus.instrucao_in = 32'h012A4020; bus.pc_mais4_in = 32'h00000008;
    sb.push_back('{pc: 32'h8, instr: 32'h012A4020, valido: 1'b1, estado: 2'd0});
    tick();
    e = sb.pop_front();
    total++; if (bus.instrucao_out !== e.instr || bus.pc_mais4_out !== e.pc) begin
      bad++; $display("FAIL norm_reg got=%h/%h exp=%h/%h", bus.instrucao_out, bus.pc_mais4_out, e.instr, e.pc);
    end
    total++; if (bus.valido !== e.valido || bus.estado !== e.estado) begin
      bad++; $display("FAIL norm_state got=%0h/%0d exp=%0h/%0d", bus.valido, bus.estado, e.valido, e.estado);
    end
    total++; if (bus.rs !== 5'd9 || bus.rt !== 5'd10 || bus.rd !== 5'd8) begin
      bad++; $display("FAIL norm_regs got=%0d/%0d/%0d exp=9/10/8", bus.rs, bus.rt, bus.rd);
    end
    total++; if (bus.funct !== 6'h20 || bus.opcode !== 6'h00 || bus.shamt !== 5'd0) begin
      bad++; $display("FAIL norm_fields got=%h/%h/%h exp=20/00/00", bus.funct, bus.opcode, bus.shamt);
    end
    total++; if (bus.pcescreve !== 1'b1) begin bad++; $display("FAIL norm_pcescreve got=%0h exp=1", bus.pcescreve); end
  endtask

  task automatic test_load_use();
    bus.id_ex_memread = 1'b1; bus.id_ex_rt = 5'd9;
    bus.instrucao_in = 32'h01095820; bus.pc_mais4_in = 32'h0000000C;
    #1;
    total++; if (bus.pcescreve !== 1'b0 || bus.bolha !== 1'b1) begin
      bad++; $display("FAIL lu_ctrl got=%0h/%0h exp=0/1", bus.pcescreve, bus.bolha);
    end
    sb.push_back('{pc: 32'h8, instr: 32'h012A4020, valido: 1'b1, estado: 2'd1});
    tick();
    e = sb.pop_front();
    total++; if (bus.instrucao_out !== e.instr || bus.pc_mais4_out !== e.pc) begin
      bad++; $display("FAIL lu_hold got=%h/%h exp=%h/%h", bus.instrucao_out, bus.pc_mais4_out, e.instr, e.pc);
    end
    total++; if (bus.estado !== e.estado) begin bad++; $display("FAIL lu_estado got=%0d exp=%0d", bus.estado, e.estado); end
    total++; if (bus.cont_stall !== 16'd1) begin bad++; $display("FAIL lu_cont_stall got=%0d exp=1", bus.cont_stall); end
    bus.id_ex_memread = 1'b0;
    #1;
    total++; if (bus.pcescreve !== 1'b1 || bus.bolha !== 1'b0) begin
      bad++; $display("FAIL lu_release got=%0h/%0h exp=1/0", bus.pcescreve, bus.bolha);
    end
    sb.push_back('{pc: 32'hC, instr: 32'h01095820, valido: 1'b1, estado: 2'd0});
    tick();
    e = sb.pop_front();
    total++; if (bus.instrucao_out !== e.instr || bus.pc_mais4_out !== e.pc || bus.estado !== e.estado) begin
      bad++; $display("FAIL lu_resume got=%h/%h/%0d exp=%h/%h/%0d", bus.instrucao_out, bus.pc_mais4_out, bus.estado, e.instr, e.pc, e.estado);
    end
    total++; if (bus.cont_stall !== 16'd1) begin bad++; $display("FAIL lu_single_stall got=%0d exp=1", bus.cont_stall); end
    // add $11,$8,$9 reads rt=9, so a load into $9 must also stall
    bus.id_ex_memread = 1'b1; bus.id_ex_rt = 5'd9;
    #1;
    total++; if (bus.bolha !== 1'b1 || bus.pcescreve !== 1'b0) begin
      bad++; $display("FAIL lu_rt_haz got=%0h/%0h exp=1/0", bus.bolha, bus.pcescreve);
    end
    bus.id_ex_memread = 1'b0;
  endtask

  task automatic test_no_false_hazard();
    bus.instrucao_in = 32'h00004020; bus.pc_mais4_in = 32'h00000010;
    tick();
    bus.id_ex_memread = 1'b1; bus.id_ex_rt = 5'd0;
    bus.instrucao_in = 32'h8D2A0000; bus.pc_mais4_in = 32'h00000014;
    #1;
    total++; if (bus.bolha !== 1'b0 || bus.pcescreve !== 1'b1) begin
      bad++; $display("FAIL nf_rt0 got=%0h/%0h exp=0/1", bus.bolha, bus.pcescreve);
    end
    sb.push_back('{pc: 32'h14, instr: 32'h8D2A0000, valido: 1'b1, estado: 2'd0});
    tick();
    e = sb.pop_front();
    total++; if (bus.instrucao_out !== e.instr || bus.pc_mais4_out !== e.pc || bus.estado !== e.estado) begin
      bad++; $display("FAIL nf_load got=%h/%h/%0d exp=%h/%h/%0d", bus.instrucao_out, bus.pc_mais4_out, bus.estado, e.instr, e.pc, e.estado);
    end
    bus.id_ex_rt = 5'd10;
    #1;
    total++; if (bus.bolha !== 1'b0 || bus.pcescreve !== 1'b1) begin
      bad++; $display("FAIL nf_lw_dest got=%0h/%0h exp=0/1", bus.bolha, bus.pcescreve);
    end
    bus.id_ex_rt = 5'd9;
    #1;
    total++; if (bus.bolha !== 1'b1) begin bad++; $display("FAIL nf_lw_rs got=%0h exp=1", bus.bolha); end
    total++; if (bus.cont_stall !== 16'd1) begin bad++; $display("FAIL nf_cont_stall got=%0d exp=1", bus.cont_stall); end
    bus.id_ex_memread = 1'b0;
  endtask

  task automatic test_flush_priority();
    bus.instrucao_in = 32'h012A4020; bus.pc_mais4_in = 32'h00000018;
    tick();
    bus.id_ex_memread = 1'b1; bus.id_ex_rt = 5'd9; bus.branch_taken = 1'b1;
    bus.instrucao_in = 32'hDEADBEEF; bus.pc_mais4_in = 32'h0000001C;
    #1;
    total++; if (bus.pcescreve !== 1'b1 || bus.bolha !== 1'b0) begin
      bad++; $display("FAIL fl_ctrl got=%0h/%0h exp=1/0", bus.pcescreve, bus.bolha);
    end
    sb.push_back('{pc: 32'h1C, instr: 32'h00000000, valido: 1'b0, estado: 2'd2});
    tick();
    e = sb.pop_front();
    total++; if (bus.instrucao_out !== e.instr || bus.pc_mais4_out !== e.pc) begin
      bad++; $display("FAIL fl_reg got=%h/%h exp=%h/%h", bus.instrucao_out, bus.pc_mais4_out, e.instr, e.pc);
    end
    total++; if (bus.valido !== e.valido || bus.estado !== e.estado) begin
      bad++; $display("FAIL fl_state got=%0h/%0d exp=%0h/%0d", bus.valido, bus.estado, e.valido, e.estado);
    end
    total++; if (bus.cont_flush !== 16'd1 || bus.cont_stall !== 16'd1) begin
      bad++; $display("FAIL fl_counters got=%0d/%0d exp=1/1", bus.cont_flush, bus.cont_stall);
    end
    bus.branch_taken = 1'b0; bus.id_ex_memread = 1'b0; bus.jump = 1'b1;
    bus.pc_mais4_in = 32'h00000020;
    sb.push_back('{pc: 32'h20, instr: 32'h00000000, valido: 1'b0, estado: 2'd2});
    tick();
    e = sb.pop_front();
    total++; if (bus.pc_mais4_out !== e.pc || bus.valido !== e.valido || bus.cont_flush !== 16'd2) begin
      bad++; $display("FAIL fl_jump got=%h/%0h/%0d exp=%h/%0h/2", bus.pc_mais4_out, bus.valido, bus.cont_flush, e.pc, e.valido);
    end
    bus.jump = 1'b0;
  endtask

  task automatic test_freeze();
    bus.instrucao_in = 32'h8D28FFFC; bus.pc_mais4_in = 32'h00000024;
    tick();
    total++; if (bus.imediato_ext !== 32'hFFFFFFFC || bus.opcode !== 6'h23) begin
      bad++; $display("FAIL fz_imm got=%h/%h exp=fffffffc/23", bus.imediato_ext, bus.opcode);
    end
    bus.congela = 1'b1; bus.branch_taken = 1'b1;
    bus.instrucao_in = 32'h11111111; bus.pc_mais4_in = 32'h00000099;
    #1;
    total++; if (bus.pcescreve !== 1'b0 || bus.bolha !== 1'b0) begin
      bad++; $display("FAIL fz_ctrl got=%0h/%0h exp=0/0", bus.pcescreve, bus.bolha);
    end
    for (int i = 0; i < 3; i++) begin
      sb.push_back('{pc: 32'h24, instr: 32'h8D28FFFC, valido: 1'b1, estado: 2'd0});
      tick();
      e = sb.pop_front();
      total++; if (bus.instrucao_out !== e.instr || bus.pc_mais4_out !== e.pc || bus.valido !== e.valido || bus.estado !== e.estado) begin
        bad++; $display("FAIL fz_hold%0d got=%h/%h/%0h/%0d exp=%h/%h/%0h/%0d", i, bus.instrucao_out, bus.pc_mais4_out, bus.valido, bus.estado, e.instr, e.pc, e.valido, e.estado);
      end
      total++; if (bus.cont_flush !== 16'd2 || bus.cont_stall !== 16'd1) begin
        bad++; $display("FAIL fz_counters%0d got=%0d/%0d exp=2/1", i, bus.cont_flush, bus.cont_stall);
      end
    end
    bus.congela = 1'b0; bus.branch_taken = 1'b0;
  endtask

  initial begin
    test_reset();
    test_normal();
    test_load_use();
    test_no_false_hazard();
    test_flush_priority();
    test_freeze();
    if (sb.size() != 0) begin
      total++; bad++;
      $display("FAIL sb_leftover got=%0d exp=0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
